tick_prescaler: RTL and testbench
=================================

// Module: tick_prescaler
// PURPOSE
//  Programmable clock-enable prescaler that drives the T (toggle-enable) input of
//  the div2 toggle stage. Counts enabled clk cycles and emits a one-cycle T pulse
//  every N cycles, so div2.Q toggles at clk/(2N). N is changed at run time through
//  a shadow register and takes effect only at a period boundary, so no short or
//  partial period ever reaches the toggle stage.
// PARAMETERS
//  WIDTH        16  width of the divisor, the shadow register and the counter
//  DEFAULT_DIV  2   divisor N loaded into the active register at reset (1..2^WIDTH-1)
// PORTS
//  clk       in   1      system clock; all state changes on the rising edge
//  CLR       in   1      asynchronous, active-high reset
//  en        in   1      count enable; when low, all counting state is frozen
//  div_in    in   WIDTH  new divisor value
//  div_load  in   1      one-cycle strobe; captures div_in into the shadow register
//  T         out  1      registered tick; high for exactly one clk per N enabled cycles
//  pending   out  1      high while the shadow holds a divisor that is not yet applied
//  cnt       out  WIDTH  current count value, range 0..N-1
// BEHAVIOUR
//  - Reset (CLR=1, asynchronous): cnt=0, T=0, pending=0, active div=DEFAULT_DIV,
//    shadow=DEFAULT_DIV. All outputs are held at these values while CLR is high.
//  - Effective divisor: Neff = (div==0) ? 1 : div. A value of 0 is legal and is
//    treated as 1.
//  - Counting on each rising edge with en=1:
//    - Wrap condition: cnt == Neff-1.
//    - On wrap: cnt <= 0 and T <= 1.
//    - Otherwise: cnt <= cnt+1 and T <= 0.
//  - Period: T rises on the edge where cnt wraps. This gives one pulse per Neff
//    enabled cycles.
//  - First pulse: the first T pulse after CLR is released is seen at the Neff-th
//    enabled edge.
//  - Neff=1: T stays high continuously while en=1 and cnt stays 0.
//  - en=0: cnt, active div and shadow hold their values (div_load is still
//    captured), and T <= 0 on the next edge. When en returns high, counting
//    resumes from the held cnt; the partial period is not restarted.
//  - Divisor update:
//    - div_load=1: shadow <= div_in and pending <= 1.
//    - A second load while pending=1 overwrites the shadow; the last value wins.
//    - On a wrap edge with pending=1: active div <= shadow and pending <= 0.
//      The new Neff governs the period that starts at that edge.
//  - Simultaneous div_load and wrap on the same edge: the wrap applies the
//    previous shadow value. The new div_in goes into the shadow, pending stays 1,
//    and the new value is applied at the following wrap.
//  - Because cnt is always 0 when a new divisor takes effect, the compare can
//    never overshoot and no wrap-around past Neff-1 is possible.
//  - CLR asserted mid-period: immediate return to reset values. Any pending
//    divisor is discarded.
// TESTING
//  1. CLR=1 for 3 cycles, then release with en=1 -> T=0, cnt=0 and pending=0
//     during reset. After release, T pulses every 2nd cycle; a downstream div2 Q
//     has a period of 4 clk.
//  2. div_load with div_in=5 at cnt=0 of a DEFAULT_DIV period -> pending=1. New
//     period of 5 starts at the next wrap and pending clears there. T spacing is
//     then exactly 5 cycles.
//  3. div_in=0, then div_in=1 -> T held high continuously, cnt=0; div2 Q toggles
//     every cycle.
//  4. Divisor 4, en low for 3 cycles at cnt=2 -> cnt holds 2 and T=0. After en
//     returns, T fires after 2 more enabled cycles.
//  5. div_load(7) on the same edge as a wrap with a prior shadow value of 3 ->
//     that wrap applies 3 and pending stays 1. The next wrap applies 7; periods
//     are 3, then 7.
//  6. CLR pulse at cnt=3 with divisor 6 and pending=1 -> immediate cnt=0, T=0,
//     pending=0. Period returns to DEFAULT_DIV.

Source files
------------

// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable clock-enable prescaler feeding the toggle-enable
// input of a div2 stage. Emits a one-cycle T pulse every Neff enabled cycles,
// where Neff = (div == 0) ? 1 : div. A new divisor is staged in a shadow
// register and only becomes active on a wrap edge, so the toggle stage never
// sees a short or partial period.
module tick_prescaler #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             T,
   output logic             pending,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] div_q,     div_d;
   logic [WIDTH-1:0] shadow_q,  shadow_d;
   logic             pending_q, pending_d;
   logic             t_q,       t_d;

   logic [WIDTH-1:0] neff;
   logic             wrap;

   // Next-state logic: count, wrap, divisor hand-over and shadow capture.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      cnt_d     = cnt_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      t_d       = 1'b0;

      // A divisor of zero is legal and behaves as one.
      neff = (div_q == '0) ? ONE : div_q;
      wrap = (cnt_q == neff - ONE);

      if (en) begin
         if (wrap) begin
            cnt_d = '0;
            t_d   = 1'b1;
            // The new divisor governs the period that starts at this edge;
            // cnt restarts at 0, so the compare can never be overshot.
            if (pending_q) begin
               div_d     = shadow_q;
               pending_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end

      // Capture comes last: a load coinciding with a wrap keeps pending set,
      // because the wrap above consumed the previous shadow value.
      if (div_load) begin
         shadow_d  = div_in;
         pending_d = 1'b1;
      end
   end

   // State registers with asynchronous clear back to the default divisor.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         cnt_q     <= '0;
         div_q     <= DIV_RST;
         shadow_q  <= DIV_RST;
         pending_q <= 1'b0;
         t_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values computed above, independent of statement order.
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         t_q       <= t_d;
      end
   end

   assign T       = t_q;
   assign pending = pending_q;
   assign cnt     = cnt_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: directed-vector bench for tick_prescaler. Each vector is
// one rising edge with its inputs and the hand-computed cnt/T/pending after it.
module tb_tick_prescaler;

   localparam int WIDTH = 16;

   typedef struct {
      logic             en;
      logic             load;
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] cnt;
      logic             t;
      logic             p;
   } vec_t;

   logic             clk = 1'b0;
   logic             clr;
   logic             en;
   logic [WIDTH-1:0] div_in;
   logic             div_load;
   logic             t;
   logic             pending;
   logic [WIDTH-1:0] cnt;

   int vectors     = 0;
   int miscompares = 0;

   tick_prescaler #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
      .clk      (clk),
      .CLR      (clr),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .T        (t),
      .pending  (pending),
      .cnt      (cnt)
   );

   always #5 clk = ~clk;

   // Apply inputs, take one rising edge, settle 1 time unit past it.
   task automatic drive_edge(input logic e, input logic ld, input logic [WIDTH-1:0] d);
      en       = e;
      div_load = ld;
      div_in   = d;
      @(posedge clk);
      #1;
      div_load = 1'b0;
   endtask

   // Async clear, held for 3 edges, then default divisor 2: T every 2nd edge.
   task automatic test_reset();
      vec_t v [4];
      clr = 1'b1; en = 1'b1; div_load = 1'b0; div_in = '0;
      #1;
      vectors++;
      if ({cnt, t, pending} !== {16'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_async: got cnt=%0d T=%b pending=%b, want cnt=0 T=0 pending=0", cnt, t, pending);
      end
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b1, 1'b1, 16'd9);
         vectors++;
         if ({cnt, t, pending} !== {16'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got cnt=%0d T=%b pending=%b, want cnt=0 T=0 pending=0", i, cnt, t, pending);
         end
      end
      clr = 1'b0;
      v = '{'{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         drive_edge(v[i].en, v[i].load, v[i].din);
         vectors++;
         if ({cnt, t, pending} !== {v[i].cnt, v[i].t, v[i].p}) begin
            miscompares++;
            $display("FAIL reset_release[%0d]: got cnt=%0d T=%b pending=%b, want cnt=%0d T=%b pending=%b",
                     i, cnt, t, pending, v[i].cnt, v[i].t, v[i].p);
         end
      end
   endtask

   // Load 5 at cnt=0: old period finishes, then T every 5 edges.
   task automatic test_divisor_update();
      vec_t v [12];
      v = '{'{1'b1, 1'b1, 16'd5, 16'd1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0}};
      for (int i = 0; i < 12; i++) begin
         drive_edge(v[i].en, v[i].load, v[i].din);
         vectors++;
         if ({cnt, t, pending} !== {v[i].cnt, v[i].t, v[i].p}) begin
            miscompares++;
            $display("FAIL div_update[%0d]: got cnt=%0d T=%b pending=%b, want cnt=%0d T=%b pending=%b",
                     i, cnt, t, pending, v[i].cnt, v[i].t, v[i].p);
         end
      end
   endtask

   // Divisor 0 then 1: both mean Neff=1, T stays high, cnt stays 0.
   task automatic test_div_zero_one();
      vec_t v [10];
      v = '{'{1'b1, 1'b1, 16'd0, 16'd1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b1, 16'd1, 16'd0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0}};
      for (int i = 0; i < 10; i++) begin
         drive_edge(v[i].en, v[i].load, v[i].din);
         vectors++;
         if ({cnt, t, pending} !== {v[i].cnt, v[i].t, v[i].p}) begin
            miscompares++;
            $display("FAIL div_zero_one[%0d]: got cnt=%0d T=%b pending=%b, want cnt=%0d T=%b pending=%b",
                     i, cnt, t, pending, v[i].cnt, v[i].t, v[i].p);
         end
      end
   endtask

   // Divisor 4, en low 3 edges at cnt=2 (load 3 while frozen), resume.
   task automatic test_enable_hold();
      vec_t v [9];
      v = '{'{1'b1, 1'b1, 16'd4, 16'd0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0},
            '{1'b0, 1'b1, 16'd3, 16'd2, 1'b0, 1'b1},
            '{1'b0, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1},
            '{1'b0, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0}};
      for (int i = 0; i < 9; i++) begin
         drive_edge(v[i].en, v[i].load, v[i].din);
         vectors++;
         if ({cnt, t, pending} !== {v[i].cnt, v[i].t, v[i].p}) begin
            miscompares++;
            $display("FAIL enable_hold[%0d]: got cnt=%0d T=%b pending=%b, want cnt=%0d T=%b pending=%b",
                     i, cnt, t, pending, v[i].cnt, v[i].t, v[i].p);
         end
      end
   endtask

   // Shadow 3 pending, load 7 on the wrap edge: periods 3 then 7.
   task automatic test_back_to_back();
      vec_t v [13];
      v = '{'{1'b1, 1'b1, 16'd3, 16'd1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'd7, 16'd0, 1'b1, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd5, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd6, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0}};
      for (int i = 0; i < 13; i++) begin
         drive_edge(v[i].en, v[i].load, v[i].din);
         vectors++;
         if ({cnt, t, pending} !== {v[i].cnt, v[i].t, v[i].p}) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: got cnt=%0d T=%b pending=%b, want cnt=%0d T=%b pending=%b",
                     i, cnt, t, pending, v[i].cnt, v[i].t, v[i].p);
         end
      end
   endtask

   // Divisor 6 pending at cnt=3, async clear: pending dropped, period back to 2.
   task automatic test_clear_mid_period();
      vec_t pre [3];
      vec_t post [6];
      pre = '{'{1'b1, 1'b1, 16'd6, 16'd1, 1'b0, 1'b1},
              '{1'b1, 1'b0, 16'd0, 16'd2, 1'b0, 1'b1},
              '{1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b1}};
      for (int i = 0; i < 3; i++) begin
         drive_edge(pre[i].en, pre[i].load, pre[i].din);
         vectors++;
         if ({cnt, t, pending} !== {pre[i].cnt, pre[i].t, pre[i].p}) begin
            miscompares++;
            $display("FAIL clear_pre[%0d]: got cnt=%0d T=%b pending=%b, want cnt=%0d T=%b pending=%b",
                     i, cnt, t, pending, pre[i].cnt, pre[i].t, pre[i].p);
         end
      end
      clr = 1'b1;
      #1;
      vectors++;
      if ({cnt, t, pending} !== {16'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL clear_async: got cnt=%0d T=%b pending=%b, want cnt=0 T=0 pending=0", cnt, t, pending);
      end
      drive_edge(1'b1, 1'b0, 16'd0);
      clr = 1'b0;
      post = '{'{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
               '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
               '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
               '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0},
               '{1'b1, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0},
               '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0}};
      for (int i = 0; i < 6; i++) begin
         drive_edge(post[i].en, post[i].load, post[i].din);
         vectors++;
         if ({cnt, t, pending} !== {post[i].cnt, post[i].t, post[i].p}) begin
            miscompares++;
            $display("FAIL clear_post[%0d]: got cnt=%0d T=%b pending=%b, want cnt=%0d T=%b pending=%b",
                     i, cnt, t, pending, post[i].cnt, post[i].t, post[i].p);
         end
      end
   endtask

   initial begin
      test_reset();
      test_divisor_update();
      test_div_zero_one();
      test_enable_hold();
      test_back_to_back();
      test_clear_mid_period();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
